// File: rtl/fifo_wptr_ctrl.sv
// Write-side pointer controller for the dual-clock LUT FIFO: binary/Gray write pointer, full, level
// and sticky overflow. Define FIFO_WPTR_ALMOST_FULL_EN to add the registered almost_full output.
module fifo_wptr_ctrl #(
  parameter int unsigned ADDR_WIDTH   = 4,
  parameter int unsigned AF_THRESHOLD = (1 << ADDR_WIDTH) - 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_req,
  input  logic [ADDR_WIDTH:0]   rd_gray_sync,
  output logic                  wr_en,
  output logic [ADDR_WIDTH-1:0] wr_addr,
  output logic [ADDR_WIDTH:0]   wr_gray,
  output logic                  full,
  output logic [ADDR_WIDTH:0]   wr_level,
  output logic                  overflow
`ifdef FIFO_WPTR_ALMOST_FULL_EN
  ,
  output logic                  almost_full
`endif
);

  localparam int unsigned PW = ADDR_WIDTH + 1;
  // Full when the write pointer equals the read pointer with its two top Gray bits inverted.
  localparam logic [ADDR_WIDTH:0] FullMask = PW'(3) << (ADDR_WIDTH - 1);

  logic [ADDR_WIDTH:0] wbin_q, wbin_d;
  logic [ADDR_WIDTH:0] wgray_q, wgray_d;
  logic [ADDR_WIDTH:0] level_q, level_d;
  logic [ADDR_WIDTH:0] rbin;
  logic                full_q, full_d;
  logic                overflow_q;
  logic                push;

  always_comb begin
    rbin = '0;
    for (int i = 0; i <= int'(ADDR_WIDTH); i++) begin
      rbin[i] = ^(rd_gray_sync >> i);
    end
  end

  always_comb begin
    push    = wr_req & ~full_q;
    wbin_d  = wbin_q + PW'(push);
    wgray_d = (wbin_d >> 1) ^ wbin_d;
    full_d  = (wgray_d == (rd_gray_sync ^ FullMask));
    level_d = wbin_d - rbin;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wbin_q     <= '0;
      wgray_q    <= '0;
      full_q     <= 1'b0;
      level_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      wbin_q     <= wbin_d;
      wgray_q    <= wgray_d;
      full_q     <= full_d;
      level_q    <= level_d;
      overflow_q <= overflow_q | (wr_req & full_q);
    end
  end

  assign wr_en    = push & ~rst;
  assign wr_addr  = wbin_q[ADDR_WIDTH-1:0];
  assign wr_gray  = wgray_q;
  assign full     = full_q;
  assign wr_level = level_q;
  assign overflow = overflow_q;

`ifdef FIFO_WPTR_ALMOST_FULL_EN
  logic almost_full_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      almost_full_q <= 1'b0;
    end else begin
      almost_full_q <= (32'(level_d) >= AF_THRESHOLD);
    end
  end

  assign almost_full = almost_full_q;
`else
  logic unused_af_threshold;
  assign unused_af_threshold = ^AF_THRESHOLD;
`endif

endmodule

// File: tb/tb_fifo_wptr_ctrl.sv
// Self-checking bench for fifo_wptr_ctrl (ADDR_WIDTH=2): occupancy-count model checked every cycle
// plus directed literal checks for reset, fill, overflow, drain, wrap and almost-full.
module tb_fifo_wptr_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       wr_req;
  logic [2:0] rd_gray_sync;
  logic       wr_en;
  logic [1:0] wr_addr;
  logic [2:0] wr_gray;
  logic       full;
  logic [2:0] wr_level;
  logic       overflow;
`ifdef FIFO_WPTR_ALMOST_FULL_EN
  logic       almost_full;
`endif

  int total = 0;
  int bad   = 0;
  bit started = 1'b0;

  always #5 clk = ~clk;

  fifo_wptr_ctrl #(
    .ADDR_WIDTH  (2),
    .AF_THRESHOLD(3)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .wr_req      (wr_req),
    .rd_gray_sync(rd_gray_sync),
    .wr_en       (wr_en),
    .wr_addr     (wr_addr),
    .wr_gray     (wr_gray),
    .full        (full),
    .wr_level    (wr_level),
    .overflow    (overflow)
`ifdef FIFO_WPTR_ALMOST_FULL_EN
    ,
    .almost_full (almost_full)
`endif
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model works in plain counts: pushes accepted so far and occupancy, both modulo 8.
  function automatic int gray_to_count(input logic [2:0] g);
    for (int b = 0; b < 8; b++) begin
      if (3'(b ^ (b >> 1)) == g) return b;
    end
    return 0;
  endfunction

  int m_w, m_level;
  bit m_full, m_ovf, m_af;

  always @(posedge clk) begin
    if (rst) begin
      m_w <= 0; m_level <= 0; m_full <= 0; m_ovf <= 0; m_af <= 0;
    end else begin
      int nw, occ;
      nw  = (m_w + ((wr_req && !m_full) ? 1 : 0)) % 8;
      occ = (nw - gray_to_count(rd_gray_sync) + 8) % 8;
      m_w     <= nw;
      m_level <= occ;
      m_full  <= (occ == 4);
      m_af    <= (occ >= 3);
      m_ovf   <= m_ovf || (wr_req && m_full);
    end
  end

  always @(negedge clk) begin
    if (started) begin
      chk("mon_wr_en", 32'(wr_en), 32'(wr_req && !m_full && !rst));
      chk("mon_wr_addr", 32'(wr_addr), 32'(m_w % 4));
      chk("mon_wr_gray", 32'(wr_gray), 32'(m_w ^ (m_w >> 1)));
      chk("mon_full", 32'(full), 32'(m_full));
      chk("mon_level", 32'(wr_level), 32'(m_level));
      chk("mon_overflow", 32'(overflow), 32'(m_ovf));
`ifdef FIFO_WPTR_ALMOST_FULL_EN
      chk("mon_almost_full", 32'(almost_full), 32'(m_af));
`endif
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  logic [2:0] fill_g [4] = '{3'b001, 3'b011, 3'b010, 3'b110};
  logic [2:0] wrap_g [8] = '{3'b001, 3'b011, 3'b010, 3'b110, 3'b111, 3'b101, 3'b100, 3'b000};

  initial begin
    logic [2:0] prev;
    rst = 1'b1;
    wr_req = 1'b1;
    rd_gray_sync = 3'b000;
    @(posedge clk);
    #1 started = 1'b1;

    // Reset held two cycles with a pending request
    @(posedge clk);
    #2;
    chk("rst_wr_en", 32'(wr_en), 0);
    chk("rst_wr_gray", 32'(wr_gray), 0);
    chk("rst_full", 32'(full), 0);
    chk("rst_level", 32'(wr_level), 0);
    chk("rst_overflow", 32'(overflow), 0);
    rst = 1'b0;
    wr_req = 1'b0;
    tick();

    // Fill
    for (int k = 0; k < 4; k++) begin
      wr_req = 1'b1;
      #1;
      chk("fill_wr_en", 32'(wr_en), 1);
      chk("fill_wr_addr", 32'(wr_addr), 32'(k));
      tick();
      chk("fill_wr_gray", 32'(wr_gray), 32'(fill_g[k]));
    end
    chk("fill_full", 32'(full), 1);
    chk("fill_level", 32'(wr_level), 4);

    // Overflow
    #1 chk("ovf_wr_en", 32'(wr_en), 0);
    tick();
    chk("ovf_wr_gray", 32'(wr_gray), 32'(3'b110));
    chk("ovf_set", 32'(overflow), 1);
    wr_req = 1'b0;
    tick();
    chk("ovf_sticky", 32'(overflow), 1);

    // Read advance in the same cycle as a push while full
    rd_gray_sync = 3'b001;
    wr_req = 1'b1;
    #1 chk("sim_rejected", 32'(wr_en), 0);
    tick();
    chk("sim_full_clr", 32'(full), 0);
    chk("sim_level", 32'(wr_level), 3);
    #1;
    chk("sim_wr_en", 32'(wr_en), 1);
    chk("sim_wr_addr", 32'(wr_addr), 0);
    tick();
    chk("sim_wr_gray", 32'(wr_gray), 32'(3'b111));
    chk("sim_full_set", 32'(full), 1);
    wr_req = 1'b0;

    rst = 1'b1;
    rd_gray_sync = 3'b000;
    tick();
    rst = 1'b0;

    // Wrap with the read pointer tracking so every push is accepted
    prev = 3'b000;
    for (int k = 0; k < 8; k++) begin
      rd_gray_sync = (k == 0) ? 3'b000 : wrap_g[k-1];
      wr_req = 1'b1;
      #1;
      chk("wrap_wr_en", 32'(wr_en), 1);
      chk("wrap_wr_addr", 32'(wr_addr), 32'(k % 4));
      tick();
      chk("wrap_wr_gray", 32'(wr_gray), 32'(wrap_g[k]));
      chk("wrap_one_bit", 32'($countones(wr_gray ^ prev)), 1);
      chk("wrap_level", 32'(wr_level), 1);
      prev = wr_gray;
    end
    wr_req = 1'b0;

`ifdef FIFO_WPTR_ALMOST_FULL_EN
    rst = 1'b1;
    rd_gray_sync = 3'b000;
    tick();
    rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      wr_req = 1'b1;
      tick();
      if (k == 1) chk("af_after_2", 32'(almost_full), 0);
    end
    chk("af_after_3", 32'(almost_full), 1);
    wr_req = 1'b0;
    rd_gray_sync = 3'b001;
    tick();
    chk("af_level_2", 32'(wr_level), 2);
    chk("af_fall", 32'(almost_full), 0);
`endif

    tick();
    tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
